// File: rtl/decode_issue_queue_if.sv
// Fetch-to-decode handshake bundle for the decode issue queue.
// The queue uses the slave view; fetch/decoder (or a bench) use the master view.
interface decode_issue_queue_if;
    logic         in_valid;
    logic [135:0] in_packet;
    logic         in_ready;
    logic         out_valid;
    logic [135:0] out_packet;
    logic         out_ready;
    logic         head_serial;

    modport slave (
        input  in_valid, in_packet, out_ready, head_serial,
        output in_ready, out_valid, out_packet
    );

    modport master (
        output in_valid, in_packet, out_ready, head_serial,
        input  in_ready, out_valid, out_packet
    );
endinterface

// File: rtl/decode_issue_queue.sv
// Instruction buffer and issue sequencer between fetch and decode.
// Packets are held in a circular buffer and the oldest is offered to the
// decoder. Instructions that must run alone wait for an empty backend
// (DRAIN), issue by themselves, then block issue until they commit (SOLO).
module decode_issue_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic                 backend_empty,
    input  logic                 serial_done,
    decode_issue_queue_if.slave  bus,
    output logic [PTR_W:0]       count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SOLO  = 2'd2
    } state_t;

    logic [135:0]     entry_q [DEPTH];
    logic [PTR_W-1:0] headPtr_q, headPtr_d;
    logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
    logic [PTR_W:0]   count_q, count_d;
    state_t           state_q, state_d;

    logic notEmpty;
    logic inReady;
    logic outValid;
    logic push;
    logic pop;

    assign notEmpty = (count_q != '0);
    // No full bypass: a pop in the same cycle never frees room for a push.
    assign inReady  = (count_q != FULL_COUNT);
    assign push     = bus.in_valid & inReady & ~flush;
    assign pop      = outValid & bus.out_ready & ~flush;

    // Offer the head only when the sequencer allows it; head_serial is only
    // meaningful while the queue holds something.
    always_comb begin
        outValid = 1'b0;
        unique case (state_q)
            RUN:     outValid = notEmpty & ~bus.head_serial;
            DRAIN:   outValid = notEmpty & backend_empty;
            default: outValid = 1'b0;
        endcase
    end

    // Next pointers, occupancy and sequencer state; flush overrides everything.
    always_comb begin
        headPtr_d = headPtr_q;
        tailPtr_d = tailPtr_q;
        count_d   = count_q;
        state_d   = state_q;
        if (flush) begin
            headPtr_d = '0;
            tailPtr_d = '0;
            count_d   = '0;
            state_d   = RUN;
        end else begin
            if (push) begin
                tailPtr_d = tailPtr_q + 1'b1;
            end
            if (pop) begin
                headPtr_d = headPtr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            unique case (state_q)
                RUN: begin
                    if (notEmpty && bus.head_serial) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        state_d = SOLO;
                    end
                end
                SOLO: begin
                    if (serial_done) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Control registers: pointers, occupancy and sequencer state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            headPtr_q <= '0;
            tailPtr_q <= '0;
            count_q   <= '0;
            state_q   <= RUN;
        end else begin
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
            count_q   <= count_d;
            state_q   <= state_d;
        end
    end

    // Packet storage is deliberately left unreset; occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_q[tailPtr_q] <= bus.in_packet;
        end
    end

    assign bus.in_ready   = inReady;
    assign bus.out_valid  = outValid;
    assign bus.out_packet = notEmpty ? entry_q[headPtr_q] : '0;
    assign count          = count_q;

endmodule
